// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched_if
// Purpose  : Bundle of the requester-side and serializer-side handshake
//            signals used by the shared UART transmit scheduler.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   req      [N_REQ]          per-requester request, held until ack
//   last     [N_REQ]          per-requester end-of-packet flag
//   data     [N_REQ*BIT_MAX]  per-requester byte, slice i = data[i*BIT_MAX +: BIT_MAX]
//   ack      [N_REQ]          one-cycle accept pulse per requester
//   tx_ready                  serializer idle and able to accept a byte
//   tx_done                   serializer end-of-stop-bit pulse
//   tx_start                  one-cycle frame start pulse to serializer
//   tx_data  [BIT_MAX]        byte to transmit
//   grant_id [clog2(N_REQ)]   index of current/last owner
//   busy                      scheduler not idle
//   err                       one-cycle tx_done timeout pulse
// Modports
//   master : environment side (requesters + serializer)
//   slave  : scheduler side
// ============================================================================
interface uart_tx_sched_if #(
  parameter int N_REQ   = 4,
  parameter int BIT_MAX = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         last;
  logic [N_REQ*BIT_MAX-1:0] data;
  logic [N_REQ-1:0]         ack;
  logic                     tx_ready;
  logic                     tx_done;
  logic                     tx_start;
  logic [BIT_MAX-1:0]       tx_data;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;
  logic                     err;

  modport master (
    output req, last, data, tx_ready, tx_done,
    input  ack, tx_start, tx_data, grant_id, busy, err
  );

  modport slave (
    input  req, last, data, tx_ready, tx_done,
    output ack, tx_start, tx_data, grant_id, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Shares one UART tx serializer among N_REQ byte requesters.
//            Round-robin arbitration; a grant is held for a whole packet
//            (until the byte flagged 'last' completes). A missing tx_done
//            aborts the packet after TIMEOUT_CYC cycles and pulses err.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_REQ       number of requesters (2..8)
//   BIT_MAX     data bits per UART frame
//   TIMEOUT_CYC clk cycles from tx_start to tx_done before abort
// Ports
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   bus  : uart_tx_sched_if.slave (req/last/data/ack requester side,
//          tx_ready/tx_done/tx_start/tx_data serializer side,
//          grant_id/busy/err status)
// Build option
//   UART_TX_SCHED_FIXED_PRIO_EN : when defined the lowest requesting index
//   wins in IDLE and no round-robin pointer exists.
// ============================================================================
module uart_tx_sched #(
  parameter int N_REQ       = 4,
  parameter int BIT_MAX     = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input wire             clk,
  input wire             rst,
  uart_tx_sched_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [BIT_MAX-1:0] tx_data_q, tx_data_d;
  logic               last_lat_q, last_lat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               err_q, err_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               rel_now;

  // Arbitration winner and the owner's current request view
  logic [ID_W-1:0]    win_id;
  logic               win_last;
  logic [BIT_MAX-1:0] win_data;
  logic               own_req;
  logic               own_last;
  logic [BIT_MAX-1:0] own_data;

`ifndef UART_TX_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]    rr_q, rr_d;
`endif

  // --------------------------------------------------------------------------
  // Winner selection for a fresh grant
  // --------------------------------------------------------------------------
  always_comb begin : p_arb
    int idx;
    idx    = 0;
    win_id = '0;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    // Scan downward so the lowest requesting index is assigned last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_id = ID_W'(i);
      end
    end
`else
    // Scan offsets from the pointer downward so the smallest offset wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (bus.req[idx]) begin
        win_id = ID_W'(idx);
      end
    end
`endif
    win_last = 1'b0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_last = bus.last[i];
        win_data = bus.data[i*BIT_MAX +: BIT_MAX];
      end
    end
  end

  always_comb begin : p_own
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        own_req  = bus.req[i];
        own_last = bus.last[i];
        own_data = bus.data[i*BIT_MAX +: BIT_MAX];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm
    state_d    = state_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    last_lat_d = last_lat_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    rel_now    = 1'b0;
    cnt_inc    = cnt_q + CNT_W'(1);
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if ((|bus.req) && bus.tx_ready) begin
          grant_d    = win_id;
          tx_data_d  = win_data;
          last_lat_d = win_last;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_inc;
        // tx_done is evaluated first so it beats a same-cycle timeout.
        if (bus.tx_done) begin
          if (!last_lat_q && own_req) begin
            if (bus.tx_ready) begin
              tx_data_d  = own_data;
              last_lat_d = own_last;
              state_d    = ST_SEND;
            end else begin
              state_d    = ST_HOLD;
            end
          end else begin
            rel_now = 1'b1;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Fires when the counter steps onto TIMEOUT_CYC-1, which puts the
          // registered err pulse TIMEOUT_CYC cycles after tx_start.
          err_d   = 1'b1;
          rel_now = 1'b1;
        end
      end

      ST_HOLD: begin
        if (!own_req) begin
          rel_now = 1'b1;
        end else if (bus.tx_ready) begin
          tx_data_d  = own_data;
          last_lat_d = own_last;
          state_d    = ST_SEND;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rel_now) begin
      state_d = ST_IDLE;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      rr_d    = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
`endif
    end

    // Outputs are decoded from the next state so they leave a flop.
    tx_start_d = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    for (int i = 0; i < N_REQ; i++) begin
      ack_d[i] = tx_start_d && (grant_d == ID_W'(i));
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      tx_data_q  <= '0;
      last_lat_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      last_lat_q <= last_lat_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched. Requester and serializer
//            models drive the interface; expected tx_start events are queued
//            per scenario and compared as the scheduler issues them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int N_REQ       = 4;
  localparam int BIT_MAX     = 8;
  localparam int TIMEOUT_CYC = 100;
  localparam int SER_DLY     = 20;
  localparam int ID_W        = $clog2(N_REQ);

  typedef struct {
    logic [ID_W-1:0]    grant;
    logic [BIT_MAX-1:0] data;
    int                 gap;    // required cycles from tx_done to tx_start, 0 = unchecked
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_sched_if #(.N_REQ(N_REQ), .BIT_MAX(BIT_MAX)) bus ();

  uart_tx_sched #(
    .N_REQ      (N_REQ),
    .BIT_MAX    (BIT_MAX),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks      = 0;
  int   errors      = 0;
  int   cyc         = 0;
  int   done_cyc    = 0;
  int   done_pulses = 0;
  int   ser_cnt     = 0;
  logic ser_hang    = 1'b0;
  logic ser_busy    = 1'b0;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [8:0]   port_q[N_REQ][$];   // {last, data} per requester

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer model: tx_done SER_DLY cycles after each tx_start unless hung.
  initial begin : p_ser
    bus.tx_ready = 1'b1;
    bus.tx_done  = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (bus.tx_start) begin
        ser_busy     = 1'b1;
        ser_cnt      = 0;
        bus.tx_ready = 1'b0;
      end else if (ser_busy) begin
        ser_cnt++;
        if (!ser_hang && ser_cnt >= SER_DLY) begin
          bus.tx_done  = 1'b1;
          bus.tx_ready = 1'b1;
          ser_busy     = 1'b0;
          done_cyc     = cyc;
          done_pulses++;
        end
      end
    end
  end

  // Requester model: present the head of each port queue, advance on ack.
  initial begin : p_req
    bus.req  = '0;
    bus.last = '0;
    bus.data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.ack[i] && port_q[i].size() > 0) void'(port_q[i].pop_front());
        if (port_q[i].size() > 0) begin
          bus.req[i]                     = 1'b1;
          bus.last[i]                    = port_q[i][0][8];
          bus.data[i*BIT_MAX +: BIT_MAX] = port_q[i][0][7:0];
        end else begin
          bus.req[i]                     = 1'b0;
          bus.last[i]                    = 1'b0;
          bus.data[i*BIT_MAX +: BIT_MAX] = '0;
        end
      end
    end
  end

  // Scoreboard consumer: every tx_start must match the next expected entry.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.tx_start) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: tx_data=%h grant=%0d, required no tx_start", bus.tx_data, bus.grant_id);
        end else begin
          mon_e = sb.pop_front();
          if (bus.tx_data !== mon_e.data || bus.grant_id !== mon_e.grant ||
              bus.ack !== (N_REQ'(1) << mon_e.grant)) begin
            errors++;
            $display("FAIL start_match: data=%h grant=%0d ack=%b, required data=%h grant=%0d",
                     bus.tx_data, bus.grant_id, bus.ack, mon_e.data, mon_e.grant);
          end
          if (mon_e.gap != 0) begin
            checks++;
            if (cyc - done_cyc != mon_e.gap) begin
              errors++;
              $display("FAIL start_latency: %0d cycles after tx_done, required %0d", cyc - done_cyc, mon_e.gap);
            end
          end
        end
      end else begin
        checks++;
        if (bus.ack !== '0) begin
          errors++;
          $display("FAIL stray_ack: ack=%b without tx_start, required 0", bus.ack);
        end
      end
    end
  end

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic queue_byte(input int p, input logic l, input logic [7:0] d);
    port_q[p].push_back({l, d});
  endtask

  task automatic expect_start(input int g, input logic [7:0] d, input int gap);
    exp_t e;
    e.grant = ID_W'(g);
    e.data  = d;
    e.gap   = gap;
    sb.push_back(e);
  endtask

  function automatic bit ports_empty();
    for (int i = 0; i < N_REQ; i++) if (port_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy && !ser_busy && ports_empty()) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d busy=%b, required all starts seen and idle", name, sb.size(), bus.busy);
    end
  endtask

  task automatic wait_sb_below(input int n, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb.size() < n) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_wait_start: pending=%0d, required below %0d", name, sb.size(), n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ack, bus.tx_start, bus.tx_data, bus.grant_id, bus.busy, bus.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b start=%b data=%h grant=%0d busy=%b err=%b, required all 0",
               bus.ack, bus.tx_start, bus.tx_data, bus.grant_id, bus.busy, bus.err);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_byte();
    @(posedge clk); #1;
    queue_byte(2, 1'b1, 8'hA5);
    expect_start(2, 8'hA5, 0);
    @(negedge clk);   // requester raises req here
    @(negedge clk);
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5 || bus.grant_id !== 2'd2 || bus.ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_latency: start=%b data=%h grant=%0d ack=%b, required 1/a5/2/0100",
               bus.tx_start, bus.tx_data, bus.grant_id, bus.ack);
    end
    @(negedge clk);
    checks++;
    if (bus.tx_start !== 1'b0 || bus.ack !== 4'b0000 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: start=%b ack=%b busy=%b, required 0/0000/1", bus.tx_start, bus.ack, bus.busy);
    end
    wait_idle("single");
  endtask

  task automatic test_rr_pointer();
    @(posedge clk); #1;
    queue_byte(1, 1'b1, 8'h21);
    queue_byte(3, 1'b1, 8'h23);
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    expect_start(1, 8'h21, 0);
    expect_start(3, 8'h23, 2);
`else
    expect_start(3, 8'h23, 0);
    expect_start(1, 8'h21, 2);
`endif
    wait_idle("rr_pointer");
  endtask

  task automatic test_fairness();
    do_reset();
    @(posedge clk); #1;
    queue_byte(0, 1'b1, 8'h10);
    queue_byte(0, 1'b1, 8'h10);
    queue_byte(1, 1'b1, 8'h11);
    queue_byte(2, 1'b1, 8'h12);
    queue_byte(3, 1'b1, 8'h13);
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    expect_start(0, 8'h10, 0);
    expect_start(0, 8'h10, 2);
    expect_start(1, 8'h11, 2);
    expect_start(2, 8'h12, 2);
    expect_start(3, 8'h13, 2);
`else
    expect_start(0, 8'h10, 0);
    expect_start(1, 8'h11, 2);
    expect_start(2, 8'h12, 2);
    expect_start(3, 8'h13, 2);
    expect_start(0, 8'h10, 2);
`endif
    wait_idle("fairness");
  endtask

  task automatic test_packet_lock();
    @(posedge clk); #1;
    queue_byte(1, 1'b0, 8'h01);
    queue_byte(1, 1'b0, 8'h02);
    queue_byte(1, 1'b1, 8'h03);
    expect_start(1, 8'h01, 0);
    expect_start(1, 8'h02, 1);
    expect_start(1, 8'h03, 1);
    wait_sb_below(3, "lock");
    @(posedge clk); #1;
    queue_byte(0, 1'b1, 8'h55);
    expect_start(0, 8'h55, 2);
    wait_idle("lock");
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    queue_byte(3, 1'b0, 8'hA0);
    expect_start(3, 8'hA0, 0);
    wait_sb_below(1, "abort");
    @(posedge clk); #1;
    queue_byte(0, 1'b1, 8'h0B);
    expect_start(0, 8'h0B, 2);
    wait_idle("abort");
  endtask

  task automatic test_timeout();
    int  s_cyc  = 0;
    int  e_cyc  = 0;
    int  pulses = 0;
    bit  seen   = 1'b0;
    bit  quiet  = 1'b1;
    ser_hang = 1'b1;
    @(posedge clk); #1;
    queue_byte(2, 1'b1, 8'h77);
    expect_start(2, 8'h77, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        s_cyc = cyc;
        break;
      end
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.err) begin
        e_cyc = cyc;
        seen  = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || e_cyc - s_cyc != TIMEOUT_CYC) begin
      errors++;
      $display("FAIL timeout_err: seen=%b after %0d cycles, required 1 after %0d", seen, e_cyc - s_cyc, TIMEOUT_CYC);
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: err=%b busy=%b, required 0/0", bus.err, bus.busy);
    end
    // Let the hung serializer finish: its tx_done now lands in IDLE.
    pulses   = done_pulses;
    ser_hang = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet || done_pulses != pulses + 1) begin
      errors++;
      $display("FAIL idle_done_ignored: quiet=%b late_done=%0d, required 1/1", quiet, done_pulses - pulses);
    end
    wait_idle("timeout");
  endtask

  task automatic test_reset_mid_wait();
    bit quiet = 1'b1;
    @(posedge clk); #1;
    queue_byte(1, 1'b1, 8'h31);
    expect_start(1, 8'h31, 0);
    wait_idle("rst_prep");
    ser_hang = 1'b1;
    @(posedge clk); #1;
    queue_byte(3, 1'b1, 8'h33);
    expect_start(3, 8'h33, 0);
    wait_sb_below(1, "rst_wait");
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd3) begin
      errors++;
      $display("FAIL rst_pre_state: busy=%b grant=%0d, required 1/3", bus.busy, bus.grant_id);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.ack, bus.tx_start, bus.tx_data, bus.grant_id, bus.busy, bus.err} !== '0) begin
      errors++;
      $display("FAIL rst_async: ack=%b start=%b data=%h grant=%0d busy=%b err=%b, required all 0",
               bus.ack, bus.tx_start, bus.tx_data, bus.grant_id, bus.busy, bus.err);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    ser_hang = 1'b0;
    for (int k = 0; k < 60 && ser_busy; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet || ser_busy) begin
      errors++;
      $display("FAIL rst_late_done: quiet=%b ser_busy=%b, required 1/0", quiet, ser_busy);
    end
    @(posedge clk); #1;
    queue_byte(1, 1'b1, 8'h41);
    queue_byte(2, 1'b1, 8'h42);
    expect_start(1, 8'h41, 0);
    expect_start(2, 8'h42, 2);
    wait_idle("rst_ptr");
  endtask

  initial begin : p_main
    test_reset();
    test_single_byte();
    test_rr_pointer();
    test_fairness();
    test_packet_lock();
    test_abort();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Shares one UART transmit serializer among N_REQ byte requesters. Each requester may send a single byte or a multi-byte packet. Arbitration is round-robin, and a grant is held until the packet's last byte has finished on the line. The block sits between application sources (echo path, status reporter, debug dump) and the tx serializer, driving that serializer's start/data handshake.

Parameters:
N_REQ, 4, number of requesters (2..8)
BIT_MAX, 8, data bits per UART frame
TIMEOUT_CYC, 65536, max clk cycles from tx_start to tx_done before abort (must exceed 10*BPS_MAX)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
req  input  N_REQ  per-requester request; held high until ack for each byte
last  input  N_REQ  per-requester flag: current byte ends its packet
data  input  N_REQ*BIT_MAX  per-requester byte; slice i = data[i*BIT_MAX +: BIT_MAX]
ack  output  N_REQ  one-cycle pulse: byte of requester i accepted
tx_ready  input  1  serializer idle and able to accept a byte
tx_done  input  1  one-cycle pulse at end of stop bit
tx_start  output  1  one-cycle pulse: start a frame with tx_data
tx_data  output  BIT_MAX  byte to transmit, valid while tx_start=1 and held until next SEND
grant_id  output  clog2(N_REQ)  index of current/last owner
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse on tx_done timeout

Behaviour:
- Reset is asynchronous, active-low, honoured in any state. All outputs are 0, state=IDLE, rr pointer=0, timeout counter=0, latched last=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State IDLE:
  - If (|req) and tx_ready: choose winner W, the first i with req[i]=1, searching from the rr pointer upward and wrapping at N_REQ.
  - Latch grant_id=W, tx_data=data slice W, lastq=last[W]. Go to SEND.
  - Otherwise stay in IDLE.
- State SEND (exactly 1 cycle):
  - tx_start=1 and ack[grant_id]=1. All other ack bits stay 0.
  - Clear the timeout counter. Go to WAIT.
- State WAIT:
  - The timeout counter increments each cycle.
  - On tx_done:
    - If lastq=0 and req[grant_id]=1 and tx_ready=1: latch the new data and last, then go to SEND. The packet is locked, so no re-arbitration occurs.
    - Otherwise (lastq=1, or req dropped mid-packet): rr pointer = grant_id+1, wrapping to 0 after N_REQ-1. Go to IDLE.
    - Case lastq=0, req=1, tx_ready=0: go to HOLD.
  - If the counter reaches TIMEOUT_CYC-1 without tx_done: err=1 for one cycle, rr pointer advances as on release, go to IDLE.
- State HOLD:
  - Wait for tx_ready=1, then latch and go to SEND.
  - If req[grant_id] drops first, release as above.
- Latency:
  - req rising (line idle) to tx_start: 1 cycle, since it is registered at the IDLE->SEND edge.
  - tx_done to next tx_start within a packet: 1 cycle.
  - Release to next grant: 2 cycles (WAIT->IDLE->SEND).
- Simultaneous events:
  - tx_done coinciding with a drop of req[grant_id]: release.
  - tx_done on the same cycle as the timeout: tx_done wins, no err.
  - New req from other ports during a locked packet: ignored until release.
- Requester contract: data/last must be stable while req=1 and before ack. After ack, the requester presents the next byte, or drops req.
- A tx_done arriving in IDLE or SEND is ignored.

Optional Feature:
UART_TX_SCHED_FIXED_PRIO_EN:
- Defined: the winner in IDLE is the lowest index with req=1. The rr pointer is not implemented; grant_id still reports the owner. Packet locking and timeout are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single byte: req[2]=1, last[2]=1, data=0xA5, tx_ready=1 -> next cycle tx_start=1, tx_data=0xA5, ack[2]=1, grant_id=2; after tx_done -> IDLE, busy=0, rr pointer=3.
- Round-robin fairness: req=4'b1111, all last=1, bytes 0x10..0x13, tx_done modelled 20 cycles after each start -> tx_data sequence 0x10, 0x11, 0x12, 0x13, 0x10; under FIXED_PRIO_EN -> 0x10 repeated.
- Packet lock: req[1] sends 3 bytes 0x01, 0x02, 0x03 (last on 3rd) while req[0] is held high -> three consecutive grants to 1, then grant to 0; tx_start 1 cycle after each tx_done.
- Abort mid-packet: req[3] drops after the first ack with last=0 -> on tx_done go to IDLE, pending req[0] is granted 2 cycles later.
- Timeout: TIMEOUT_CYC=100, tx_done never pulses -> err=1 exactly 100 cycles after tx_start, busy=0 next cycle, ack never repeats.
- Reset mid-WAIT: rst low for 1 cycle during WAIT -> all outputs 0 immediately, a late tx_done is ignored, next req is granted from pointer 0.
